note_sequencer: RTL

Step sequencer directly upstream of the synth voice. It produces the trig gate and the osc_count pitch word that the synth consumes. It plays a writable pattern of STEPS entries at a tempo of TEMPO ticks per step, replacing the fixed trig pin and fixed pulse period with a looping melody. The voice's ADSR retriggers on every rising trig edge and releases when trig falls.

---
 rtl/synth_pkg.sv | 31 +++
 rtl/seq_tick_prescaler.sv | 49 ++++
 rtl/note_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the note sequencer and the voice-side register map.
//   - Pattern entry layout, MSB first: {en, gate_len[LEN_W], osc[OSC_W]}.
//     The bit offsets are computed from the field widths so that every
//     parameterisation uses the same layout.
//   - Sequencer FSM state encoding.
// -----------------------------------------------------------------------------
package synth_pkg;

  // The oscillator field always sits at the bottom of an entry.
  localparam int OSC_LSB = 0;

  // The gate length field sits directly above the oscillator field.
  function automatic int entry_len_lsb(input int osc_w);
    return OSC_LSB + osc_w;
  endfunction

  // The enable flag is the entry MSB.
  function automatic int entry_en_bit(input int len_w, input int osc_w);
    return entry_len_lsb(osc_w) + len_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_GATE  = 2'd2,
    ST_REST  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_tick_prescaler.sv
// -----------------------------------------------------------------------------
// seq_tick_prescaler
// Free-running divider: counts 0..TICK_DIV-1 while enabled and raises tick
// for the single cycle in which the count wraps.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   clr  - synchronous clear; holds the count at 0 and suppresses tick
//   en   - count enable
//   tick - one-cycle pulse on the wrap cycle
// -----------------------------------------------------------------------------
module seq_tick_prescaler #(
  parameter int TICK_DIV = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wrap;

  always_comb begin
    wrap  = en && !clr && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = wrap;

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Step sequencer feeding the synth voice. Plays a writable STEPS-entry pattern,
// one step every max(tempo,1) ticks of a TICK_DIV clock prescaler. Each step
// drives the voice pitch word and a gate of gate_len ticks.
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset
//   run         - 1 = play, 0 = stop (level)
//   tempo       - ticks per step, 0 treated as 1
//   wr_en       - pattern write strobe
//   wr_addr     - pattern entry index
//   wr_data     - {en, gate_len, osc}
//   trig        - gate to the voice
//   osc_count   - pitch word (half-period) to the voice
//   step_idx    - index of the step currently playing
//   step_strobe - one-cycle pulse at every step start
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module note_sequencer
  import synth_pkg::*;
#(
  parameter int  STEPS    = 16,
  parameter int  OSC_W    = 8,
  parameter int  LEN_W    = 8,
  parameter int  TICK_DIV = 10000,
  localparam int IDX_W    = $clog2(STEPS),
  localparam int ENT_W    = 1 + LEN_W + OSC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [LEN_W-1:0] tempo,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [ENT_W-1:0] wr_data,
  output logic             trig,
  output logic [OSC_W-1:0] osc_count,
  output logic [IDX_W-1:0] step_idx,
  output logic             step_strobe
);

  localparam int EN_BIT  = entry_en_bit(LEN_W, OSC_W);
  localparam int LEN_LSB = entry_len_lsb(OSC_W);

  // Pattern storage
  logic [ENT_W-1:0] pattern_q [STEPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        pattern_q[i] <= '0;
      end
    end else if (wr_en) begin
      pattern_q[wr_addr] <= wr_data;
    end
  end

  // State and working registers
  seq_state_e       state_q,       state_d;
  logic [IDX_W-1:0] step_idx_q,    step_idx_d;
  logic [OSC_W-1:0] osc_count_q,   osc_count_d;
  logic             trig_q,        trig_d;
  logic             step_strobe_q, step_strobe_d;
  logic             ent_en_q,      ent_en_d;
  logic [LEN_W-1:0] gate_len_q,    gate_len_d;
  logic [LEN_W-1:0] step_cnt_q,    step_cnt_d;
  logic [LEN_W-1:0] gate_cnt_q,    gate_cnt_d;

  logic             tick;
  logic             prescale_clr;
  logic             load;
  logic [IDX_W-1:0] load_idx;
  logic [ENT_W-1:0] load_entry;
  logic [LEN_W:0]   tempo_eff;
  logic [LEN_W:0]   step_cnt_inc;
  logic             step_end;

  // Holding the prescaler clear while idle means it always restarts from 0
  // on the cycle after run rises, giving a fixed tick phase per run.
  assign prescale_clr = (state_q == ST_IDLE);

  seq_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (prescale_clr),
    .en   (1'b1),
    .tick (tick)
  );

  // The step boundary is decided on the tick itself (counter value after
  // this tick), so a step lasts exactly tempo ticks. One extra bit keeps the
  // compare safe when the counter sits at its maximum.
  assign tempo_eff    = (tempo == '0) ? (LEN_W + 1)'(1) : {1'b0, tempo};
  assign step_cnt_inc = {1'b0, step_cnt_q} + (LEN_W + 1)'(1);
  assign step_end     = tick && (step_cnt_inc >= tempo_eff);

  always_comb begin
    state_d       = state_q;
    step_idx_d    = step_idx_q;
    osc_count_d   = osc_count_q;
    ent_en_d      = ent_en_q;
    gate_len_d    = gate_len_q;
    step_cnt_d    = step_cnt_q;
    gate_cnt_d    = gate_cnt_q;
    load          = 1'b0;
    load_idx      = step_idx_q + IDX_W'(1);
    load_entry    = '0;

    // Both tick counters saturate so a long gate_len or a raised tempo
    // cannot wrap them back to zero.
    if (tick) begin
      if (step_cnt_q != '1) step_cnt_d = step_cnt_q + LEN_W'(1);
      if (gate_cnt_q != '1) gate_cnt_d = gate_cnt_q + LEN_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d  = ST_START;
          load     = 1'b1;
          load_idx = '0;
        end
      end
      ST_START: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (!ent_en_q || (gate_len_q == '0)) begin
          state_d = ST_REST;
        end else begin
          state_d = ST_GATE;
        end
      end
      ST_GATE: begin
        // The step boundary wins over the gate end, which is what keeps
        // trig high to the boundary when gate_len >= tempo.
        if (!run) begin
          state_d = ST_IDLE;
        end else if (step_end) begin
          state_d = ST_START;
          load    = 1'b1;
        end else if (gate_cnt_q >= gate_len_q) begin
          state_d = ST_REST;
        end
      end
      ST_REST: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (step_end) begin
          state_d = ST_START;
          load    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Entry fields are captured once per step; later writes to the same
    // entry only show up on its next visit.
    if (load) begin
      load_entry  = pattern_q[load_idx];
      step_idx_d  = load_idx;
      ent_en_d    = load_entry[EN_BIT];
      gate_len_d  = load_entry[LEN_LSB +: LEN_W];
      osc_count_d = load_entry[OSC_LSB +: OSC_W];
      step_cnt_d  = '0;
      gate_cnt_d  = '0;
    end

    // Outputs are registered from the next state so they line up with it.
    trig_d        = (state_d == ST_GATE);
    step_strobe_d = (state_d == ST_START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      step_idx_q    <= '0;
      osc_count_q   <= '0;
      trig_q        <= 1'b0;
      step_strobe_q <= 1'b0;
      ent_en_q      <= 1'b0;
      gate_len_q    <= '0;
      step_cnt_q    <= '0;
      gate_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      step_idx_q    <= step_idx_d;
      osc_count_q   <= osc_count_d;
      trig_q        <= trig_d;
      step_strobe_q <= step_strobe_d;
      ent_en_q      <= ent_en_d;
      gate_len_q    <= gate_len_d;
      step_cnt_q    <= step_cnt_d;
      gate_cnt_q    <= gate_cnt_d;
    end
  end

  assign trig        = trig_q;
  assign osc_count   = osc_count_q;
  assign step_idx    = step_idx_q;
  assign step_strobe = step_strobe_q;

endmodule
